i2s_receiver: RTL

Serial audio receiver for the audio subsystem; the capture-side counterpart of the 16-bit MSB-first bclk/lrclk/din transmitter that drives the DAC. Oversamples the three serial pins in the system clock domain, deserialises left-justified 16-bit words and presents each completed left/right pair on a valid/ready interface. Used for loopback verification of the playback path and for line-in capture.

---
 rtl/audio_pkg.sv | 11 +
 rtl/sync_edge.sv | 28 ++
 rtl/i2s_receiver.sv | 194 +++++++++++++++++++
 3 files changed

// File: rtl/audio_pkg.sv
// Shared audio-subsystem types: receiver state encoding and sample width.
package audio_pkg;
  localparam int SAMPLE_WIDTH = 16;
  localparam int BIT_COUNT_W  = $clog2(SAMPLE_WIDTH + 1);

  typedef enum logic [1:0] {
    HUNT,
    RX_WORD,
    WAIT_EDGE
  } i2s_rx_state_t;
endpackage

// File: rtl/sync_edge.sv
// Two-flop synchronizer for one asynchronous pin with a registered falling-edge pulse.
module sync_edge (
  input  logic clk,
  input  logic rst,
  input  logic pin,
  output logic level,
  output logic fall
);
  logic sync_1;
  logic sync_2;
  logic sync_2_q;

  always_ff @(posedge clk) begin
    if (!rst) begin
      sync_1   <= 1'b0;
      sync_2   <= 1'b0;
      sync_2_q <= 1'b0;
      fall     <= 1'b0;
    end else begin
      sync_1   <= pin;
      sync_2   <= sync_1;
      sync_2_q <= sync_2;
      fall     <= sync_2_q & ~sync_2;
    end
  end

  assign level = sync_2;
endmodule

// File: rtl/i2s_receiver.sv
// Left-justified 16-bit serial audio receiver with a valid/ready pair output.
// Optional build macro I2S_RX_ERROR_COUNT_EN adds a saturating frame-error counter port.
//
// state     | meaning
// HUNT      | after reset, waiting for the first lrclk transition
// RX_WORD   | shifting in the bits of the current word
// WAIT_EDGE | word complete, waiting for lrclk to change
module i2s_receiver
  import audio_pkg::*;
(
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    audio_bclk,
  input  logic                    audio_lrclk,
  input  logic                    audio_din,
  output logic [SAMPLE_WIDTH-1:0] o_left,
  output logic [SAMPLE_WIDTH-1:0] o_right,
  output logic                    o_valid,
  input  logic                    i_ready,
  output logic                    o_overflow,
  output logic                    o_frameError
`ifdef I2S_RX_ERROR_COUNT_EN
  ,
  output logic [15:0]             o_errorCount
`endif
);
  i2s_rx_state_t state, state_n;

  logic strike;
  logic lr_s;
  logic din_s;
  logic unused_bclk_level;
  logic unused_lr_fall;
  logic unused_din_fall;

  logic [SAMPLE_WIDTH-1:0] shift_q, shift_n;
  logic [SAMPLE_WIDTH-1:0] hold_l, hold_l_n;
  logic [SAMPLE_WIDTH-1:0] hold_r, hold_r_n;
  logic [SAMPLE_WIDTH-1:0] word;
  logic [SAMPLE_WIDTH-1:0] left_n, right_n;
  logic [BIT_COUNT_W-1:0]  bit_count, bit_count_n;
  logic prev_lr, prev_lr_n;
  logic seen, seen_n;
  logic left_have, left_have_n;
  logic lr_chg;
  logic pair_done;
  logic frame_err_n;
  logic valid_n;
  logic overflow_n;

  sync_edge u_sync_bclk (
    .clk   (clk),
    .rst   (rst),
    .pin   (audio_bclk),
    .level (unused_bclk_level),
    .fall  (strike)
  );

  sync_edge u_sync_lrclk (
    .clk   (clk),
    .rst   (rst),
    .pin   (audio_lrclk),
    .level (lr_s),
    .fall  (unused_lr_fall)
  );

  sync_edge u_sync_din (
    .clk   (clk),
    .rst   (rst),
    .pin   (audio_din),
    .level (din_s),
    .fall  (unused_din_fall)
  );

  always_ff @(posedge clk) begin
    if (!rst) begin
      state        <= HUNT;
      shift_q      <= '0;
      hold_l       <= '0;
      hold_r       <= '0;
      bit_count    <= '0;
      prev_lr      <= 1'b0;
      seen         <= 1'b0;
      left_have    <= 1'b0;
      o_left       <= '0;
      o_right      <= '0;
      o_valid      <= 1'b0;
      o_overflow   <= 1'b0;
      o_frameError <= 1'b0;
    end else begin
      state        <= state_n;
      shift_q      <= shift_n;
      hold_l       <= hold_l_n;
      hold_r       <= hold_r_n;
      bit_count    <= bit_count_n;
      prev_lr      <= prev_lr_n;
      seen         <= seen_n;
      left_have    <= left_have_n;
      o_left       <= left_n;
      o_right      <= right_n;
      o_valid      <= valid_n;
      o_overflow   <= overflow_n;
      o_frameError <= frame_err_n;
    end
  end

  // "seen" suppresses a false transition on the very first strike after reset.
  assign lr_chg = seen && (lr_s != prev_lr);
  assign word   = {shift_q[SAMPLE_WIDTH-2:0], din_s};

  always_comb begin
    state_n     = state;
    shift_n     = shift_q;
    hold_l_n    = hold_l;
    hold_r_n    = hold_r;
    bit_count_n = bit_count;
    prev_lr_n   = prev_lr;
    seen_n      = seen;
    left_have_n = left_have;
    frame_err_n = 1'b0;
    pair_done   = 1'b0;

    if (strike) begin
      seen_n    = 1'b1;
      prev_lr_n = lr_s;
      unique case (state)
        HUNT: begin
          if (lr_chg) begin
            shift_n     = {{(SAMPLE_WIDTH-1){1'b0}}, din_s};
            bit_count_n = BIT_COUNT_W'(1);
            state_n     = RX_WORD;
          end
        end
        RX_WORD: begin
          if (lr_chg) begin
            frame_err_n = 1'b1;
            if (!prev_lr) left_have_n = 1'b0;
            shift_n     = {{(SAMPLE_WIDTH-1){1'b0}}, din_s};
            bit_count_n = BIT_COUNT_W'(1);
          end else begin
            shift_n     = word;
            bit_count_n = bit_count + BIT_COUNT_W'(1);
            if (bit_count == BIT_COUNT_W'(SAMPLE_WIDTH - 1)) begin
              state_n = WAIT_EDGE;
              if (!lr_s) begin
                hold_l_n    = word;
                left_have_n = 1'b1;
              end else if (left_have) begin
                hold_r_n    = word;
                left_have_n = 1'b0;
                pair_done   = 1'b1;
              end
            end
          end
        end
        WAIT_EDGE: begin
          if (lr_chg) begin
            shift_n     = {{(SAMPLE_WIDTH-1){1'b0}}, din_s};
            bit_count_n = BIT_COUNT_W'(1);
            state_n     = RX_WORD;
          end else begin
            frame_err_n = 1'b1;
          end
        end
        default: state_n = HUNT;
      endcase
    end

    left_n     = o_left;
    right_n    = o_right;
    valid_n    = o_valid & ~i_ready;
    overflow_n = o_overflow;
    // A pair completing on the handshake cycle replaces the one being consumed.
    if (pair_done) begin
      if (!o_valid || i_ready) begin
        left_n  = hold_l;
        right_n = hold_r_n;
        valid_n = 1'b1;
      end else begin
        overflow_n = 1'b1;
      end
    end
  end

`ifdef I2S_RX_ERROR_COUNT_EN
  always_ff @(posedge clk) begin
    if (!rst) begin
      o_errorCount <= '0;
    end else if (o_frameError && (o_errorCount != 16'hFFFF)) begin
      o_errorCount <= o_errorCount + 16'd1;
    end
  end
`endif
endmodule
